// File: rtl/redmule_pkg.sv
// Shared RedMulE types: element formats, array geometry and the control/flag
// structs exchanged between the controller and the datapath buffers.
package redmule_pkg;

  typedef enum logic [1:0] {
    FP8  = 2'd0,
    FP16 = 2'd1,
    FP32 = 2'd2
  } fp_format_e;

  localparam int unsigned ARRAY_WIDTH  = 12;
  localparam int unsigned ARRAY_HEIGHT = 4;
  localparam int unsigned LFTOVR_W     = 8;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP8:     return 8;
      FP16:    return 16;
      FP32:    return 32;
      default: return 16;
    endcase
  endfunction

  // X/W input buffers
  typedef struct packed {
    logic                load;
    logic                rst_w_index;
    logic [LFTOVR_W-1:0] width;
    logic [LFTOVR_W-1:0] height;
  } x_buffer_ctrl_t;

  typedef struct packed {
    logic full;
    logic empty;
  } x_buffer_flgs_t;

  // Z drain buffer: a zero leftover means "use the full dimension"
  typedef struct packed {
    logic                fill;
    logic [LFTOVR_W-1:0] cols_lftovr;
    logic [LFTOVR_W-1:0] rows_lftovr;
  } z_drain_ctrl_t;

  typedef struct packed {
    logic fill_ready;
    logic full;
    logic empty;
  } z_drain_flgs_t;

endpackage

// File: rtl/redmule_z_drain_if.sv
// Row stream leaving the Z drain buffer. A row transfers on a clock edge where
// valid && ready; while valid is high and ready low, data/strb hold stable.
interface redmule_z_drain_if #(
  parameter int unsigned DW = 288
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [DW/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/redmule_z_drain.sv
// Collects array result columns into a Width x D tile, then streams it out
// row by row with element/byte masking for partial (leftover) tiles.
module redmule_z_drain
  import redmule_pkg::*;
#(
  parameter int unsigned  DW       = 288,
  parameter fp_format_e   FpFormat = FP16,
  parameter int unsigned  Width    = ARRAY_WIDTH,
  localparam int unsigned BITW     = fp_width(FpFormat),
  localparam int unsigned D        = DW / BITW
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  z_drain_ctrl_t               ctrl_i,
  output z_drain_flgs_t               flags_o,
  input  logic [Width-1:0][BITW-1:0]  z_i,
  output logic                        z_valid_o,
  input  logic                        z_ready_i,
  output logic [DW-1:0]               z_data_o,
  output logic [DW/8-1:0]             z_strb_o
);

  localparam int unsigned CW    = $clog2(D) + 1;
  localparam int unsigned RW    = $clog2(Width) + 1;
  localparam int unsigned CIW   = $clog2(D);
  localparam int unsigned RIW   = $clog2(Width);
  localparam int unsigned BYTES = BITW / 8;

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]                           state_q;
  logic [CW-1:0]                        col_cnt_q;
  logic [RW-1:0]                        row_cnt_q;
  logic [CW-1:0]                        depth_q;
  logic [RW-1:0]                        limit_q;
  logic [Width-1:0][D-1:0][BITW-1:0]    buf_q;

  logic [CW-1:0]  new_depth;
  logic [RW-1:0]  new_limit;
  logic [CW-1:0]  fill_depth;
  logic [CIW-1:0] col_idx;
  logic [RIW-1:0] row_idx;

  assign new_depth = (ctrl_i.cols_lftovr == '0) ? CW'(D)     : ctrl_i.cols_lftovr[CW-1:0];
  assign new_limit = (ctrl_i.rows_lftovr == '0) ? RW'(Width) : ctrl_i.rows_lftovr[RW-1:0];
  // The first fill of a tile must already see its own depth (a 1-column tile ends at once)
  assign fill_depth = (col_cnt_q == '0) ? new_depth : depth_q;
  assign col_idx    = col_cnt_q[CIW-1:0];
  assign row_idx    = row_cnt_q[RIW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FILL;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      depth_q   <= '0;
      limit_q   <= '0;
      buf_q     <= '0;
    end else if (clear_i) begin
      state_q   <= FILL;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      depth_q   <= '0;
      limit_q   <= '0;
      buf_q     <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (ctrl_i.fill) begin
            for (int h = 0; h < Width; h++) begin
              buf_q[h][col_idx] <= z_i[h];
            end
            if (col_cnt_q == '0) begin
              depth_q <= new_depth;
              limit_q <= new_limit;
            end
            if (col_cnt_q == fill_depth - CW'(1)) begin
              col_cnt_q <= '0;
              state_q   <= DRAIN;
            end else begin
              col_cnt_q <= col_cnt_q + CW'(1);
            end
          end
        end
        DRAIN: begin
          // valid is the state bit itself, so ready alone completes a handshake
          if (z_ready_i) begin
            if (row_cnt_q == limit_q - RW'(1)) begin
              row_cnt_q <= '0;
              state_q   <= FILL;
            end else begin
              row_cnt_q <= row_cnt_q + RW'(1);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign z_valid_o          = (state_q == DRAIN);
  assign flags_o.fill_ready = (state_q == FILL);
  assign flags_o.full       = (state_q == DRAIN);
  assign flags_o.empty      = (state_q == FILL) && (col_cnt_q == '0);

  always_comb begin
    z_data_o = '0;
    z_strb_o = '0;
    if (state_q == DRAIN) begin
      for (int d = 0; d < D; d++) begin
        if (CW'(d) < depth_q) begin
          z_data_o[d*BITW +: BITW]  = buf_q[row_idx][d];
          z_strb_o[d*BYTES +: BYTES] = '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_redmule_z_drain.sv
// Bench for redmule_z_drain: tile model in plain arrays, expected rows queued
// at fill time and checked by a negedge monitor on every row handshake.
module tb_redmule_z_drain;
  import redmule_pkg::*;

  localparam int unsigned DW   = 288;
  localparam int unsigned BITW = 16;
  localparam int unsigned D    = 18;
  localparam int unsigned W    = 12;
  localparam int unsigned SW   = DW / 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    clear = 1'b0;
  z_drain_ctrl_t           ctrl;
  z_drain_flgs_t           flags;
  logic [W-1:0][BITW-1:0]  z;

  redmule_z_drain_if #(.DW(DW)) zif ();

  logic [DW-1:0] exp_q[$];
  logic [SW-1:0] exp_strb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  redmule_z_drain #(.DW(DW), .FpFormat(FP16), .Width(W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (clear),
    .ctrl_i    (ctrl),
    .flags_o   (flags),
    .z_i       (z),
    .z_valid_o (zif.valid),
    .z_ready_i (zif.ready),
    .z_data_o  (zif.data),
    .z_strb_o  (zif.strb)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a row transfers on the next posedge when valid && ready
  always @(negedge clk) begin
    if (rst_n && zif.valid && zif.ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_row: got %0h expected no row", zif.data);
      end else begin
        check("row_data", zif.data, exp_q.pop_front());
        check("row_strb", DW'(zif.strb), DW'(exp_strb_q.pop_front()));
      end
    end
  end

  // drive one tile and queue its expected rows
  task automatic fill_tile(input int cols, input int rows, input bit rnd);
    int depth;
    int limit;
    logic [BITW-1:0] tile [W][D];
    logic [DW-1:0] row;
    logic [SW-1:0] strb;
    depth = (cols == 0) ? D : cols;
    limit = (rows == 0) ? W : rows;
    for (int h = 0; h < W; h++)
      for (int c = 0; c < D; c++)
        tile[h][c] = rnd ? BITW'($urandom) : BITW'(h * D + c);
    ctrl.cols_lftovr = LFTOVR_W'(cols);
    ctrl.rows_lftovr = LFTOVR_W'(rows);
    ctrl.fill = 1'b1;
    for (int c = 0; c < depth; c++) begin
      for (int h = 0; h < W; h++) z[h] = tile[h][c];
      @(posedge clk); #1;
    end
    ctrl.fill = 1'b0;
    z = '0;
    for (int r = 0; r < limit; r++) begin
      row = '0;
      strb = '0;
      for (int c = 0; c < depth; c++) begin
        row[c*BITW +: BITW] = tile[r][c];
        strb[c*2 +: 2] = 2'b11;
      end
      exp_q.push_back(row);
      exp_strb_q.push_back(strb);
    end
    check("first_row_latency", zif.valid, 1'b1);
  endtask

  task automatic drain_tile(input bit rnd_ready, input bit junk, input int exp_cycles);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    if (junk) begin
      ctrl.fill = 1'b1;
      z = '1;
    end
    while (!done && cyc < 400) begin
      zif.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (exp_q.size() == 0) done = 1'b1;
      else if (junk) check("fill_ready_in_drain", flags.fill_ready, 1'b0);
    end
    ctrl.fill = 1'b0;
    z = '0;
    zif.ready = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d rows left expected 0", exp_q.size());
    end
    check("back_to_fill", {flags.full, flags.fill_ready, zif.valid}, 3'b010);
    if (exp_cycles > 0) check("drain_cycles", cyc, exp_cycles);
  endtask

  initial begin
    ctrl = '0;
    z = '0;
    zif.ready = 1'b0;

    // reset state, before any clock edge
    #1;
    check("reset_flags", flags, 3'b101);
    check("reset_valid", zif.valid, 1'b0);
    check("reset_data", zif.data, '0);
    check("reset_strb", DW'(zif.strb), '0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // full tile, consecutive rows
    fill_tile(0, 0, 1'b0);
    drain_tile(1'b0, 1'b0, 12);

    // leftovers 5 cols x 3 rows
    fill_tile(5, 3, 1'b0);
    drain_tile(1'b0, 1'b0, 3);

    // backpressure on row 2
    fill_tile(0, 0, 1'b1);
    zif.ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    zif.ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("bp_valid", zif.valid, 1'b1);
      check("bp_data", zif.data, exp_q[0]);
    end
    drain_tile(1'b0, 1'b0, 10);

    // fill requests ignored while draining
    fill_tile(0, 0, 1'b1);
    drain_tile(1'b0, 1'b1, 12);

    // clear after 6 rows
    fill_tile(0, 0, 1'b0);
    zif.ready = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    clear = 1'b1;
    zif.ready = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_valid", zif.valid, 1'b0);
    check("clear_flags", flags, 3'b101);
    check("clear_strb", DW'(zif.strb), '0);
    exp_q.delete();
    exp_strb_q.delete();
    fill_tile(0, 0, 1'b1);
    drain_tile(1'b0, 1'b0, 12);

    // random tiles, random backpressure
    repeat (8) begin
      fill_tile(int'($urandom_range(0, D)), int'($urandom_range(0, W)), 1'b1);
      drain_tile(1'b1, 1'($urandom_range(0, 1)), 0);
    end

    // async reset mid-fill (9 columns in)
    ctrl = '0;
    ctrl.fill = 1'b1;
    repeat (9) begin
      for (int h = 0; h < W; h++) z[h] = BITW'($urandom);
      @(posedge clk); #1;
    end
    ctrl.fill = 1'b0;
    z = '0;
    check("midfill_empty", flags.empty, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_fill_flags", flags, 3'b101);
    check("async_fill_valid", zif.valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_tile(0, 0, 1'b0);
    drain_tile(1'b0, 1'b0, 12);

    // async reset mid-drain
    fill_tile(0, 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_drain_valid", zif.valid, 1'b0);
    check("async_drain_data", zif.data, '0);
    check("async_drain_flags", flags, 3'b101);
    exp_q.delete();
    exp_strb_q.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_tile(3, 2, 1'b1);
    drain_tile(1'b0, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
